// File: rtl/spi_mosi_tx.sv
// -----------------------------------------------------------------------------
// spi_mosi_tx
//
// Serial MOSI shifter for the SSD1331 panel, fed by the N-byte MOSI buffer.
// SPI mode 3 (SCLK idles high, data changes on the falling edge and the slave
// samples on the rising edge), MSB first. A one-cycle o_FINAL_BIT pulse is
// raised as the last bit of a word begins. This gives the buffer time to
// present the next word before the word boundary. If i_START is high at that
// boundary, the next word follows with no SCLK gap and CS_N stays low.
//
// Parameters:
//   WIDTH    - bits per serial word
//   CLK_DIV  - system cycles per SCLK half-period (>= 1)
//   CS_SETUP - CS_N setup count before the first SCLK fall (>= 1)
//   CS_HOLD  - CS_N hold count after the last SCLK rise (>= 1)
//
// Ports:
//   i_SCK        system clock, rising edge
//   i_RST        asynchronous active-high reset (aborts any transfer)
//   i_DATA       word to shift, sampled only when a word is loaded
//   i_START      word available (level)
//   i_DC         data/command flag belonging to i_DATA
//   o_SCLK       SPI clock, idles high
//   o_MOSI       serial data
//   o_CS_N       chip select, active low
//   o_DC         D/C to the panel, updated at the first falling edge of a word
//   o_FINAL_BIT  one-cycle pulse on the first cycle of bit 0
//   o_BUSY       high whenever the FSM is not idle
//
// Optional feature (macro SPI_MOSI_TX_BYTE_CNT_EN):
//   o_BYTE_CNT   16-bit count of completed words (wraps)
//   o_CMD_SEEN   sticky flag, set when a word with D/C = 0 completes
// -----------------------------------------------------------------------------
module spi_mosi_tx #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             i_SCK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_DATA,
  input  logic             i_START,
  input  logic             i_DC,
  output logic             o_SCLK,
  output logic             o_MOSI,
  output logic             o_CS_N,
  output logic             o_DC,
  output logic             o_FINAL_BIT,
  output logic             o_BUSY
`ifdef SPI_MOSI_TX_BYTE_CNT_EN
  ,
  output logic [15:0]      o_BYTE_CNT,
  output logic             o_CMD_SEEN
`endif
);

  localparam int BIT_W  = $clog2(WIDTH) + 1;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CS_W   = $clog2(CS_MAX + 1);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CS_W-1:0]  SETUP_LAST = CS_W'(CS_SETUP);
  localparam logic [CS_W-1:0]  HOLD_LAST  = CS_W'(CS_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_reg,    state_next;
  logic [WIDTH-1:0]   shift_reg,    shift_next;
  logic               dc_latch_reg, dc_latch_next;
  logic [DIV_W-1:0]   div_cnt_reg,  div_cnt_next;
  logic [BIT_W-1:0]   bit_cnt_reg,  bit_cnt_next;
  logic [CS_W-1:0]    cs_cnt_reg,   cs_cnt_next;
  logic               phase_reg,    phase_next;   // 0 = SCLK low half, 1 = high half
  logic               sclk_reg,     sclk_next;
  logic               mosi_reg,     mosi_next;
  logic               cs_n_reg,     cs_n_next;
  logic               dc_reg,       dc_next;
  logic               final_reg,    final_next;

  // State and output registers
  always_ff @(posedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      dc_latch_reg <= 1'b0;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      cs_cnt_reg   <= '0;
      phase_reg    <= 1'b0;
      sclk_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      dc_reg       <= 1'b0;
      final_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      dc_latch_reg <= dc_latch_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      cs_cnt_reg   <= cs_cnt_next;
      phase_reg    <= phase_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      cs_n_reg     <= cs_n_next;
      dc_reg       <= dc_next;
      final_reg    <= final_next;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    dc_latch_next = dc_latch_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    cs_cnt_next   = cs_cnt_reg;
    phase_next    = phase_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    cs_n_next     = cs_n_reg;
    dc_next       = dc_reg;
    final_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_START) begin
          shift_next    = i_DATA;
          dc_latch_next = i_DC;
          cs_n_next     = 1'b0;
          cs_cnt_next   = '0;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (cs_cnt_reg == SETUP_LAST) begin
          // First falling edge of the word: MSB out, D/C to the panel
          cs_cnt_next  = '0;
          state_next   = SHIFT;
          sclk_next    = 1'b0;
          phase_next   = 1'b0;
          div_cnt_next = '0;
          bit_cnt_next = BIT_LAST;
          mosi_next    = shift_reg[WIDTH-1];
          shift_next   = shift_reg << 1;
          dc_next      = dc_latch_reg;
          final_next   = (WIDTH == 1);
        end else begin
          cs_cnt_next = cs_cnt_reg + 1'b1;
        end
      end

      SHIFT: begin
        if (div_cnt_reg != DIV_LAST) begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end else begin
          div_cnt_next = '0;
          if (!phase_reg) begin
            // End of the low half: rising edge, slave samples MOSI
            phase_next = 1'b1;
            sclk_next  = 1'b1;
          end else if (bit_cnt_reg != '0) begin
            // End of a high half with bits remaining: next bit on the fall
            bit_cnt_next = bit_cnt_reg - 1'b1;
            phase_next   = 1'b0;
            sclk_next    = 1'b0;
            mosi_next    = shift_reg[WIDTH-1];
            shift_next   = shift_reg << 1;
            final_next   = (bit_cnt_reg == BIT_ONE);
          end else if (i_START) begin
            // Word boundary with another word ready: reload and keep going
            dc_latch_next = i_DC;
            phase_next    = 1'b0;
            sclk_next     = 1'b0;
            bit_cnt_next  = BIT_LAST;
            mosi_next     = i_DATA[WIDTH-1];
            shift_next    = i_DATA << 1;
            dc_next       = i_DC;
            final_next    = (WIDTH == 1);
          end else begin
            // Word boundary, nothing queued: SCLK and MOSI hold, CS hold time
            state_next  = HOLD;
            cs_cnt_next = '0;
          end
        end
      end

      HOLD: begin
        if (cs_cnt_reg == HOLD_LAST) begin
          cs_cnt_next = '0;
          cs_n_next   = 1'b1;
          state_next  = IDLE;
        end else begin
          cs_cnt_next = cs_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_SCLK      = sclk_reg;
  assign o_MOSI      = mosi_reg;
  assign o_CS_N      = cs_n_reg;
  assign o_DC        = dc_reg;
  assign o_FINAL_BIT = final_reg;
  assign o_BUSY      = (state_reg != IDLE);

`ifdef SPI_MOSI_TX_BYTE_CNT_EN
  logic        word_done;
  logic [15:0] byte_cnt_reg;
  logic        cmd_seen_reg;

  // Last cycle of bit 0's high half, whether or not another word follows
  assign word_done = (state_reg == SHIFT) && phase_reg &&
                     (div_cnt_reg == DIV_LAST) && (bit_cnt_reg == '0);

  always_ff @(posedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      byte_cnt_reg <= '0;
      cmd_seen_reg <= 1'b0;
    end else if (word_done) begin
      byte_cnt_reg <= byte_cnt_reg + 16'd1;
      if (!dc_reg) begin
        cmd_seen_reg <= 1'b1;
      end
    end
  end

  assign o_BYTE_CNT = byte_cnt_reg;
  assign o_CMD_SEEN = cmd_seen_reg;
`endif

endmodule

// File: tb/tb_spi_mosi_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_mosi_tx
//
// Directed bench for spi_mosi_tx. Instance 0 uses the default parameters.
// Instances 1 and 2 use CLK_DIV=1 and CLK_DIV=4. A per-cycle monitor inside
// step() records SCLK edges, MOSI bits captured on rising edges, CS_N windows
// and o_FINAL_BIT pulses. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_mosi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       dc_in;
  logic [2:0] start_v;

  wire  [2:0] sclk_w, mosi_w, cs_w, dc_w, fin_w, busy_w;

`ifdef SPI_MOSI_TX_BYTE_CNT_EN
  wire [15:0] cnt0, cnt1, cnt4;
  wire        cmd0, cmd1, cmd4;
`endif

  always #5 clk = ~clk;

  spi_mosi_tx #(.WIDTH(8), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_START(start_v[0]), .i_DC(dc_in),
    .o_SCLK(sclk_w[0]), .o_MOSI(mosi_w[0]), .o_CS_N(cs_w[0]), .o_DC(dc_w[0]),
    .o_FINAL_BIT(fin_w[0]), .o_BUSY(busy_w[0])
`ifdef SPI_MOSI_TX_BYTE_CNT_EN
    , .o_BYTE_CNT(cnt0), .o_CMD_SEEN(cmd0)
`endif
  );

  spi_mosi_tx #(.WIDTH(8), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) dut1 (
    .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_START(start_v[1]), .i_DC(dc_in),
    .o_SCLK(sclk_w[1]), .o_MOSI(mosi_w[1]), .o_CS_N(cs_w[1]), .o_DC(dc_w[1]),
    .o_FINAL_BIT(fin_w[1]), .o_BUSY(busy_w[1])
`ifdef SPI_MOSI_TX_BYTE_CNT_EN
    , .o_BYTE_CNT(cnt1), .o_CMD_SEEN(cmd1)
`endif
  );

  spi_mosi_tx #(.WIDTH(8), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut4 (
    .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_START(start_v[2]), .i_DC(dc_in),
    .o_SCLK(sclk_w[2]), .o_MOSI(mosi_w[2]), .o_CS_N(cs_w[2]), .o_DC(dc_w[2]),
    .o_FINAL_BIT(fin_w[2]), .o_BUSY(busy_w[2])
`ifdef SPI_MOSI_TX_BYTE_CNT_EN
    , .o_BYTE_CNT(cnt4), .o_CMD_SEEN(cmd4)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Monitor state, one slot per instance
  int          divs[3] = '{2, 1, 4};
  int          cyc = 0;
  int          n0;
  logic [2:0]  prev_sclk, prev_cs;
  logic [31:0] bits[3];
  logic [7:0]  dc_log;
  int rises[3], falls[3], finals[3], first_final[3], first_fall[3], second_fall[3];
  int last_rise[3], cs_falls[3], cs_rises[3], cs_fall_cyc[3], cs_rise_cyc[3];
  int cs_low[3], run[3], bad[3];
  logic [2:0]  win_first;

  logic [7:0]  buf_data[8];
  logic        buf_dc[8];

  task automatic clear_mon();
    prev_sclk = sclk_w;
    prev_cs   = cs_w;
    win_first = 3'b000;
    dc_log    = '0;
    for (int i = 0; i < 3; i++) begin
      bits[i] = '0; rises[i] = 0; falls[i] = 0; finals[i] = 0; first_final[i] = -1;
      first_fall[i] = -1; second_fall[i] = -1; last_rise[i] = -1; cs_falls[i] = 0;
      cs_rises[i] = 0; cs_fall_cyc[i] = -1; cs_rise_cyc[i] = -1; cs_low[i] = 0;
      run[i] = 0; bad[i] = 0;
    end
  endtask

  // One clock, then sample everything half a period after the rising edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (fin_w[i]) begin
        finals[i]++;
        if (first_final[i] < 0) first_final[i] = cyc;
      end
      if (prev_cs[i] && !cs_w[i]) begin
        cs_falls[i]++; cs_fall_cyc[i] = cyc; win_first[i] = 1'b1;
      end
      if (!prev_cs[i] && cs_w[i]) begin
        cs_rises[i]++; cs_rise_cyc[i] = cyc;
      end
      if (!cs_w[i]) cs_low[i]++;
      if (prev_sclk[i] && !sclk_w[i]) begin
        if (!win_first[i] && run[i] != divs[i]) bad[i]++;
        win_first[i] = 1'b0;
        if (falls[i] == 0) first_fall[i] = cyc;
        else if (falls[i] == 1) second_fall[i] = cyc;
        if (i == 0 && (falls[0] % 8) == 0) dc_log = {dc_log[6:0], dc_w[0]};
        falls[i]++;
        run[i] = 1;
      end else if (!prev_sclk[i] && sclk_w[i]) begin
        if (run[i] != divs[i]) bad[i]++;
        bits[i] = {bits[i][30:0], mosi_w[i]};
        rises[i]++;
        last_rise[i] = cyc;
        run[i] = 1;
      end else begin
        run[i]++;
      end
    end
    prev_sclk = sclk_w;
    prev_cs   = cs_w;
  endtask

  // Buffer model on instance 0: presents a word, drops i_START once the word
  // has started shifting, and presents the next one on o_FINAL_BIT.
  task automatic burst(input int nb, input int ncyc);
    int idx;
    int pf;
    clear_mon();
    idx        = 0;
    data       = buf_data[0];
    dc_in      = buf_dc[0];
    start_v[0] = 1'b1;
    n0         = cyc + 1;
    step();
    start_v[0] = 1'b0;
    data       = ~buf_data[0];
    dc_in      = ~buf_dc[0];
    for (int k = 1; k < ncyc; k++) begin
      pf = falls[0];
      step();
      if (start_v[0] && falls[0] != pf) begin
        start_v[0] = 1'b0;
        data       = ~data;
        dc_in      = ~dc_in;
      end
      if (fin_w[0]) begin
        idx++;
        if (idx < nb) begin
          data       = buf_data[idx];
          dc_in      = buf_dc[idx];
          start_v[0] = 1'b1;
        end
      end
    end
    start_v[0] = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    data    = 8'h00;
    dc_in   = 1'b0;
    start_v = 3'b000;
    clear_mon();
    repeat (3) step();

    // Reset state
    check_val("rst_cs_n",  cs_w[0],   1);
    check_val("rst_sclk",  sclk_w[0], 1);
    check_val("rst_mosi",  mosi_w[0], 0);
    check_val("rst_dc",    dc_w[0],   0);
    check_val("rst_final", fin_w[0],  0);
    check_val("rst_busy",  busy_w[0], 0);
    rst = 1'b0;
    step();
    step();

    // Single command byte A5
    buf_data[0] = 8'hA5; buf_dc[0] = 1'b0;
    burst(1, 60);
    check_val("a5_bits",      bits[0][7:0], 8'hA5);
    check_val("a5_rises",     rises[0], 8);
    check_val("a5_finals",    finals[0], 1);
    check_val("a5_cs_fall",   cs_fall_cyc[0] - n0, 0);
    check_val("a5_sclk_fall", first_fall[0] - n0, 3);
    check_val("a5_final_at",  first_final[0] - n0, 31);
    check_val("a5_cs_rise",   cs_rise_cyc[0] - n0, 38);
    check_val("a5_cs_wins",   cs_falls[0], 1);
    check_val("a5_phases",    bad[0], 0);
    check_val("a5_dc",        dc_w[0], 0);
    check_val("a5_busy_end",  busy_w[0], 0);

    // Back-to-back 81,7F,00 with DC 1,1,0
    buf_data[0] = 8'h81; buf_dc[0] = 1'b1;
    buf_data[1] = 8'h7F; buf_dc[1] = 1'b1;
    buf_data[2] = 8'h00; buf_dc[2] = 1'b0;
    burst(3, 140);
    check_val("b2b_bits",    bits[0][23:0], 24'h817F00);
    check_val("b2b_rises",   rises[0], 24);
    check_val("b2b_finals",  finals[0], 3);
    check_val("b2b_cs_wins", cs_falls[0], 1);
    check_val("b2b_cs_rise", cs_rises[0], 1);
    check_val("b2b_no_gap",  bad[0], 0);
    check_val("b2b_dc_log",  dc_log[2:0], 3'b110);
    check_val("b2b_span",    last_rise[0] - first_fall[0], 94);
    check_val("b2b_cs_end",  cs_rise_cyc[0] - n0, 102);

    // Divider sweep, one FF byte on CLK_DIV=1 and CLK_DIV=4
    clear_mon();
    data    = 8'hFF;
    dc_in   = 1'b1;
    start_v = 3'b110;
    n0      = cyc + 1;
    step();
    start_v = 3'b000;
    data    = 8'h00;
    dc_in   = 1'b0;
    repeat (100) step();
    check_val("div1_shift_len", last_rise[1] - first_fall[1] + 1, 16);
    check_val("div1_period",    second_fall[1] - first_fall[1], 2);
    check_val("div1_bits",      bits[1][7:0], 8'hFF);
    check_val("div1_rises",     rises[1], 8);
    check_val("div1_phases",    bad[1], 0);
    check_val("div1_finals",    finals[1], 1);
    check_val("div1_dc",        dc_w[1], 1);
    check_val("div1_busy_end",  busy_w[1], 0);
    check_val("div4_shift_len", last_rise[2] - first_fall[2] + 4, 64);
    check_val("div4_period",    second_fall[2] - first_fall[2], 8);
    check_val("div4_bits",      bits[2][7:0], 8'hFF);
    check_val("div4_rises",     rises[2], 8);
    check_val("div4_phases",    bad[2], 0);
    check_val("div4_first_fall", first_fall[2] - n0, 3);
    check_val("div4_dc",        dc_w[2], 1);
    check_val("div4_busy_end",  busy_w[2], 0);
    check_val("div_main_idle",  falls[0], 0);

    // START pulsed during HOLD is ignored
    clear_mon();
    data       = 8'h3C;
    dc_in      = 1'b1;
    start_v[0] = 1'b1;
    n0         = cyc + 1;
    step();
    start_v[0] = 1'b0;
    data       = 8'h00;
    repeat (35) step();
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    step();
    check_val("hold_cs_rise", cs_w[0], 1);
    check_val("hold_busy",    busy_w[0], 0);
    repeat (5) step();
    check_val("hold_no_restart", cs_falls[0], 1);
    check_val("hold_falls",      falls[0], 8);
    check_val("hold_bits",       bits[0][7:0], 8'h3C);
    buf_data[0] = 8'hC3; buf_dc[0] = 1'b0;
    burst(1, 60);
    check_val("restart_cs_fall", cs_fall_cyc[0] - n0, 0);
    check_val("restart_setup",   first_fall[0] - n0, 3);
    check_val("restart_bits",    bits[0][7:0], 8'hC3);
    check_val("restart_cs_rise", cs_rise_cyc[0] - n0, 38);

    // Asynchronous reset in the middle of a word (bit 4 of 96, SCLK low, MOSI 1)
    clear_mon();
    data       = 8'h96;
    dc_in      = 1'b1;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (15) step();
    check_val("pre_rst_cs",   cs_w[0], 0);
    check_val("pre_rst_sclk", sclk_w[0], 0);
    check_val("pre_rst_mosi", mosi_w[0], 1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_cs_n",  cs_w[0], 1);
    check_val("arst_sclk",  sclk_w[0], 1);
    check_val("arst_busy",  busy_w[0], 0);
    check_val("arst_mosi",  mosi_w[0], 0);
    check_val("arst_final", fin_w[0], 0);
    check_val("arst_dc",    dc_w[0], 0);
    step();
    step();
    rst = 1'b0;
    clear_mon();
    repeat (12) step();
    check_val("post_rst_falls",  falls[0], 0);
    check_val("post_rst_cs_low", cs_low[0], 0);
    check_val("post_rst_busy",   busy_w[0], 0);

`ifdef SPI_MOSI_TX_BYTE_CNT_EN
    // Five words, the third a command
    buf_data[0] = 8'h11; buf_dc[0] = 1'b1;
    buf_data[1] = 8'h22; buf_dc[1] = 1'b1;
    buf_data[2] = 8'h33; buf_dc[2] = 1'b0;
    buf_data[3] = 8'h44; buf_dc[3] = 1'b1;
    buf_data[4] = 8'h55; buf_dc[4] = 1'b1;
    burst(5, 220);
    check_val("cnt_bits",     bits[0], 32'h22334455);
    check_val("cnt_value",    cnt0, 5);
    check_val("cnt_cmd_seen", cmd0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_val("cnt_rst",      cnt0, 0);
    check_val("cnt_cmd_rst",  cmd0, 0);
    check_val("cnt1_rst",     cnt1, 0);
    check_val("cnt4_rst",     cnt4, 0);
    check_val("cmd1_rst",     cmd1, 0);
    check_val("cmd4_rst",     cmd4, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
